// File: rtl/seq_detector_param.sv
// Serial pattern detector with a runtime-loadable pattern, a per-bit care mask and an
// overlap/non-overlap mode. It also provides a saturating match counter and a fill (progress) count.
module seq_detector_param #(
  parameter int               PAT_W   = 4,
  parameter int               CNT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = 4'b1101
) (
  input  logic                         clock,
  input  logic                         resetn,
  input  logic                         w,
  input  logic                         w_valid,
  input  logic                         pat_load,
  input  logic [PAT_W-1:0]             pat_in,
  input  logic [PAT_W-1:0]             mask_in,
  input  logic                         overlap_in,
  input  logic                         count_clr,
  output logic                         match,
  output logic [CNT_W-1:0]             match_count,
  output logic [$clog2(PAT_W+1)-1:0]   fill,
  output logic [PAT_W-1:0]             pat_q
);

  localparam int FILL_W = $clog2(PAT_W+1);
  localparam logic [FILL_W-1:0] FULL    = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {FILLING = 1'b0, ARMED = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PAT_W-1:0]   pat_d;
  logic [PAT_W-1:0]   mask_q, mask_d;
  logic               ovl_q, ovl_d;

  logic [PAT_W-1:0]   hist_n;
  logic [FILL_W-1:0]  fill_n;
  logic               hit;

  // A pattern load takes priority over a valid bit, so a hit can only come from a consumed bit.
  always_comb begin
    hist_n = {hist_q[PAT_W-2:0], w};
    fill_n = (state_q == ARMED) ? FULL : fill_q + 1'b1;
    hit    = w_valid && !pat_load && (fill_n == FULL) &&
             (((hist_n ^ pat_q) & mask_q) == '0);
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q <= FILLING;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      cnt_q   <= '0;
      pat_q   <= DEF_PAT;
      mask_q  <= '1;
      ovl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      mask_q  <= mask_d;
      ovl_q   <= ovl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hist_d  = hist_q;
    fill_d  = fill_q;
    match_d = 1'b0;
    pat_d   = pat_q;
    mask_d  = mask_q;
    ovl_d   = ovl_q;
    cnt_d   = cnt_q;

    if (pat_load) begin
      pat_d   = pat_in;
      mask_d  = mask_in;
      ovl_d   = overlap_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILLING;
    end else if (w_valid) begin
      hist_d  = hist_n;
      match_d = hit;
      // A non-overlapping hit discards the window, so the next match needs PAT_W fresh bits.
      if (hit && !ovl_q) begin
        fill_d  = '0;
        state_d = FILLING;
      end else begin
        fill_d  = fill_n;
        state_d = (fill_n == FULL) ? ARMED : FILLING;
      end
    end

    if (count_clr)
      cnt_d = '0;
    else if (hit && (cnt_q != CNT_MAX))
      cnt_d = cnt_q + 1'b1;
  end

  assign match       = match_q;
  assign match_count = cnt_q;
  assign fill        = fill_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. The default instance runs every scenario;
// a CNT_W=2 instance shares the same inputs and is used to exercise counter saturation.
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic       w = 1'b0;
  logic       w_valid = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic [3:0] mask_in = 4'b0000;
  logic       overlap_in = 1'b0;
  logic       count_clr = 1'b0;

  logic       match_a, match_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic [2:0] fill_a, fill_b;
  logic [3:0] pat_a, pat_b;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  seq_detector_param dut_a (
    .clock(clock), .resetn(resetn), .w(w), .w_valid(w_valid), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap_in(overlap_in), .count_clr(count_clr),
    .match(match_a), .match_count(count_a), .fill(fill_a), .pat_q(pat_a)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clock(clock), .resetn(resetn), .w(w), .w_valid(w_valid), .pat_load(pat_load),
    .pat_in(pat_in), .mask_in(mask_in), .overlap_in(overlap_in), .count_clr(count_clr),
    .match(match_b), .match_count(count_b), .fill(fill_b), .pat_q(pat_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic b);
    w = b;
    w_valid = 1'b1;
    tick();
    w_valid = 1'b0;
  endtask

  task automatic idle();
    w_valid = 1'b0;
    tick();
  endtask

  task automatic load(input logic [3:0] p, input logic [3:0] m, input logic o);
    pat_in = p;
    mask_in = m;
    overlap_in = o;
    pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
  endtask

  task automatic clr();
    count_clr = 1'b1;
    tick();
    count_clr = 1'b0;
  endtask

  // bits[n-1] is sent first; exp[i] is the match expected after sending bits[i].
  task automatic run_seq(input logic [15:0] bits, input logic [15:0] exp, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i]);
      chk($sformatf("%s_bit%0d", tag, n - i), 32'(match_a), 32'(exp[i]));
      $display("%s bit%0d w=%0b match=%0b fill=%0d count=%0d", tag, n - i, bits[i], match_a, fill_a, count_a);
    end
  endtask

  initial begin
    // Reset state
    resetn = 1'b0;
    tick();
    tick();
    chk("rst_match", 32'(match_a), 32'(1'b0));
    chk("rst_count", 32'(count_a), 32'(8'd0));
    chk("rst_fill",  32'(fill_a),  32'(3'd0));
    chk("rst_pat",   32'(pat_a),   32'(4'b1101));
    resetn = 1'b1;

    // 1: default 1101, overlap
    run_seq(16'b1101101, 16'b0001001, 7, "t1");
    chk("t1_fill",  32'(fill_a),  32'(3'd4));
    chk("t1_count", 32'(count_a), 32'(8'd2));

    // 2: non-overlap
    clr();
    load(4'b1101, 4'b1111, 1'b0);
    send(1'b1); send(1'b1); send(1'b0); send(1'b1);
    chk("t2_match4", 32'(match_a), 32'(1'b1));
    chk("t2_fill4",  32'(fill_a),  32'(3'd0));
    run_seq(16'b101, 16'b000, 3, "t2");
    chk("t2_fill",  32'(fill_a),  32'(3'd3));
    chk("t2_count", 32'(count_a), 32'(8'd1));

    // 3: all ones, overlap then non-overlap
    clr();
    load(4'b1111, 4'b1111, 1'b1);
    run_seq(16'b111111, 16'b000111, 6, "t3o");
    chk("t3o_count", 32'(count_a), 32'(8'd3));
    clr();
    load(4'b1111, 4'b1111, 1'b0);
    run_seq(16'hFF, 16'b00010001, 8, "t3n");
    chk("t3n_count", 32'(count_a), 32'(8'd2));

    // 4: don't-care middle bits
    clr();
    load(4'b1001, 4'b1001, 1'b1);
    run_seq(16'b1111, 16'b0001, 4, "t4a");
    load(4'b1001, 4'b1001, 1'b1);
    run_seq(16'b0111, 16'b0000, 4, "t4b");
    chk("t4_count", 32'(count_a), 32'(8'd1));

    // Empty mask, non-overlap: a hit on every 4th bit
    clr();
    load(4'b0000, 4'b0000, 1'b0);
    run_seq(16'b10110010, 16'b00010001, 8, "tm0");
    chk("tm0_count", 32'(count_a), 32'(8'd2));

    // 5: 2-bit counter saturates, clear wins over a hit
    clr();
    load(4'b1111, 4'b1111, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      send(1'b1);
      if (k >= 4) begin
        chk($sformatf("t5_cnt_k%0d", k), 32'(count_b), 32'((k - 3 > 3) ? 3 : k - 3));
        $display("t5 hit%0d count_b=%0d", k - 3, count_b);
      end
    end
    count_clr = 1'b1;
    send(1'b1);
    count_clr = 1'b0;
    chk("t5_clr_match", 32'(match_b), 32'(1'b1));
    chk("t5_clr_cntb",  32'(count_b), 32'(2'd0));
    chk("t5_clr_cnta",  32'(count_a), 32'(8'd0));

    // 6a: a pattern load mid-stream discards the history and the bit presented on the same edge
    load(4'b1101, 4'b1111, 1'b1);
    run_seq(16'b110, 16'b000, 3, "t6a");
    w = 1'b1;
    w_valid = 1'b1;
    pat_load = 1'b1;
    tick();
    pat_load = 1'b0;
    w_valid = 1'b0;
    chk("t6a_fill_ld", 32'(fill_a), 32'(3'd0));
    send(1'b1);
    chk("t6a_match", 32'(match_a), 32'(1'b0));
    chk("t6a_fill",  32'(fill_a),  32'(3'd1));

    // 6b: reset mid-stream restores the default pattern and clears the count
    load(4'b1111, 4'b1111, 1'b1);
    run_seq(16'b1111, 16'b0001, 4, "t6b");
    chk("t6b_count_pre", 32'(count_a), 32'(8'd1));
    run_seq(16'b110, 16'b110, 3, "t6b2");
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    send(1'b1);
    chk("t6b_match", 32'(match_a), 32'(1'b0));
    chk("t6b_count", 32'(count_a), 32'(8'd0));
    chk("t6b_pat",   32'(pat_a),   32'(4'b1101));
    chk("t6b_fill",  32'(fill_a),  32'(3'd1));

    // 6c: gaps between valid bits
    load(4'b1101, 4'b1111, 1'b1);
    send(1'b1); idle();
    send(1'b1); idle(); idle();
    send(1'b0);
    chk("t6c_match3", 32'(match_a), 32'(1'b0));
    idle();
    send(1'b1);
    chk("t6c_match4", 32'(match_a), 32'(1'b1));
    idle();
    chk("t6c_gap", 32'(match_a), 32'(1'b0));
    chk("t6c_fill", 32'(fill_a), 32'(3'd4));
    $display("t6c match after gapped bits, count=%0d", count_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector. It is the next generation of the fixed-sequence Moore detectors used in the lab designs. A runtime-loadable pattern of PAT_W bits, a per-bit care mask and an overlap/non-overlap mode replace the hard-coded state graph. It sits between switch/key input conditioning and LED/HEX display logic, and also exposes a saturating match counter and a fill (progress) indicator.

Parameters:
- PAT_W, 4, pattern length in bits; legal range 2..16.
- CNT_W, 8, width of the saturating match counter.
- DEF_PAT, 4'b1101, pattern loaded at reset; width PAT_W.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- w  in  1  serial data bit.
- w_valid  in  1  w is consumed on this edge when 1.
- pat_load  in  1  load pat_in, mask_in and overlap_in on this edge.
- pat_in  in  PAT_W  new pattern. Bit PAT_W-1 is the oldest (first-received) bit; bit 0 is the newest.
- mask_in  in  PAT_W  care mask; 1 = bit compared, 0 = don't care.
- overlap_in  in  1  1 = overlapping matches allowed, 0 = non-overlapping.
- count_clr  in  1  clears match_count.
- match  out  1  registered one-cycle pulse on pattern detection.
- match_count  out  CNT_W  saturating count of matches.
- fill  out  $clog2(PAT_W+1)  number of valid history bits, 0..PAT_W.
- pat_q  out  PAT_W  currently active pattern, for display.

Behaviour:
- Reset is synchronous, active-low, on reset resetn, clock clock. When resetn=0 at an edge:
  - hist=0, fill=0, match=0, match_count=0
  - pat_q=DEF_PAT, mask=all ones, overlap=1
  - Reset overrides every other input.
- Priority at each edge: resetn, then pat_load, then w_valid. count_clr is evaluated independently of these three.
- pat_load=1:
  - pat_q<=pat_in, mask<=mask_in, overlap<=overlap_in.
  - hist=0, fill=0, match=0; match_count is unchanged.
  - A w_valid bit presented on the same edge is discarded.
- w_valid=1 and pat_load=0:
  - hist_n = {hist[PAT_W-2:0], w}.
  - fill_n = min(fill+1, PAT_W).
  - hit = (fill_n==PAT_W) && (((hist_n ^ pat_q) & mask)==0).
  - On the edge: hist<=hist_n, match<=hit.
  - If hit and overlap=0, fill<=0, so the next match needs PAT_W fresh bits. Otherwise fill<=fill_n.
- w_valid=0: hist and fill hold; match<=0. match is therefore never high for two cycles unless a hit occurs on consecutive valid bits.
- Latency: match rises in the cycle after the edge that consumed the completing bit (Moore output, registered; no combinational path from w to match).
- match_count:
  - Increments by 1 on each edge where hit=1; saturates at 2^CNT_W-1 with no wrap.
  - If count_clr=1 on the same edge as a hit, the clear wins and the result is 0.
  - pat_load does not clear match_count.
- mask=0 (all zeros): hit occurs whenever fill_n reaches PAT_W, i.e. every PAT_W-th bit in non-overlap mode and every bit once full in overlap mode.
- Implementation: an explicit control FSM with states FILLING (fill<PAT_W) and ARMED (fill==PAT_W).
  - ARMED falls back to FILLING on a non-overlap hit or on pat_load.
  - The FSM state is derived from or consistent with fill.
  - Transitions and outputs are coded in separate processes.

Test Plan:
1. PAT_W=4, default pattern 1101, overlap=1; feed valid bits 1,1,0,1,1,0,1 -> match pulses after bits 4 and 7; match_count=2; fill=4 from bit 4 onward.
2. Same stimulus with pat_load (pat_in=1101, mask_in=1111, overlap_in=0) first -> single match after bit 4; fill returns to 0 then reaches 3 at bit 7; match_count=1.
3. Load 1111 with overlap=1 and feed six 1s -> matches after bits 4,5,6 and count=3. Repeat with overlap=0, feeding eight 1s -> matches after bits 4 and 8 only.
4. Load pat 1001, mask 1001; feed 1,1,1,1 -> match (middle bits don't care). Feed 0,1,1,1 -> no match.
5. Build CNT_W=2; produce 5 matches -> count 1,2,3,3,3. Assert count_clr on the edge of a 6th hit -> count=0.
6. Mid-operation events:
   - Feed 1,1,0, then pat_load (same pattern), then 1 -> no match, fill=1.
   - Feed 1,1,0, then resetn=0 for one edge, then 1 -> no match, count=0, pat_q=1101.
   - Insert w_valid=0 gaps between bits of 1101 -> match still after the 4th valid bit.
